pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the MIPS32 processor. It consumes the branch-taken decision (`branch & Zero`) and the jump control, computes the next PC, and fetches each instruction through a ready-handshaked instruction-memory port. It presents one instruction at a time to decode/execute and counts retired instructions and taken redirects.

## Interface
- `RESET_PC`, default 32'h0000_0000 — PC loaded on reset; must be word-aligned.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `pc_src` in 1 — branch taken (`branch & Zero`); sampled only in EXEC.
- `jump` in 1 — unconditional jump; sampled only in EXEC.
- `sign_imm` in 32 — sign-extended 16-bit branch offset, in words.
- `jump_field` in 26 — instr[25:0] of a J-type instruction.
- `halt` in 1 — stop after the current instruction; sampled only in EXEC.
- `imem_req` out 1 — fetch request.
- `imem_addr` out 32 — fetch address, equal to `pc_out`.
- `imem_ready` in 1 — memory has `instr_in` valid this cycle.
- `instr_in` in 32 — fetched instruction word.
- `instr_out` out 32 — latched instruction for decode.
- `instr_valid` out 1 — `instr_out` is executing this cycle.
- `pc_out` out 32 — PC of the fetched or executing instruction.
- `pc_plus4` out 32 — `pc_out + 4` (combinational, mod 2^32).
- `retire_count` out 32 — instructions retired; wraps.
- `redirect_count` out 16 — taken branches and jumps; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALTED.
  - IDLE: the reset state; goes to FETCH on the first edge after reset is released.
  - FETCH: `imem_req`=1. On an edge with `imem_ready`=1, latch `instr_in` into `instr_out` and go to EXEC. Otherwise stay in FETCH and hold `imem_req`, with `imem_addr` stable.
  - EXEC: `instr_valid`=1 and `imem_req`=0. At the edge:
    - `pc` <= next_pc;
    - `retire_count` += 1;
    - `redirect_count` += 1 if `jump|pc_src` (saturating);
    - go to HALTED if `halt`, else to FETCH.
  - HALTED: terminal. `imem_req`=0 and `instr_valid`=0; PC and counters frozen. Only reset exits.
- next_pc priority: `jump` > `pc_src` > sequential.
  - jump target = {pc_plus4[31:28], jump_field, 2'b00}.
  - branch target = pc_plus4 + (sign_imm << 2), truncated to 32 bits (wraps).
  - sequential = pc_plus4; PC 32'hFFFF_FFFC wraps to 0.
- On a halting instruction the PC still updates, so `pc_out` in HALTED is the successor address.
- `pc_src`, `jump`, `halt`, `sign_imm` and `jump_field` are don't-care outside EXEC.
- Reset values (asserted asynchronously while `rst_n`=0):
  - state IDLE;
  - `pc_out`=`imem_addr`=RESET_PC;
  - `pc_plus4`=RESET_PC+4;
  - `imem_req`=0, `instr_valid`=0, `instr_out`=0;
  - `retire_count`=0, `redirect_count`=0.

## Timing
- `imem_req`, `instr_valid` and `imem_addr` are decoded from registered state and PC only, with no combinational path from any input.
- Minimum latency is 2 cycles per instruction (FETCH with `imem_ready`=1, then EXEC). Each wait cycle with `imem_ready`=0 adds one cycle.
- First request: `imem_req` rises one cycle after `rst_n` deasserts (IDLE→FETCH).
- `imem_ready` while not in FETCH is ignored.
- Reset asserted mid-FETCH or mid-EXEC aborts immediately: `imem_req`/`instr_valid` drop in the same cycle, and the pending redirect and count updates are lost.
- `jump` and `pc_src` both high: the jump wins, and `redirect_count` increments once.

## Test plan
- Reset with RESET_PC=32'h0040_0000, `imem_ready` tied 1, no branches: `imem_addr` sequence 0x00400000, 0x00400004, 0x00400008 on alternate cycles; `retire_count`=3 after 6 cycles following IDLE.
- Branch: at PC 0x100, `pc_src`=1 and `sign_imm`=32'hFFFF_FFFE in EXEC: next `imem_addr`=0x0FC and `redirect_count`=1. Repeat with `sign_imm`=3: 0x110.
- Jump priority: PC 0x9000_0010, `jump`=1 and `pc_src`=1, `jump_field`=26'h0000_040: next address 0x9000_0100; `redirect_count` increments by exactly 1.
- Wait states: `imem_ready` low for 3 cycles in FETCH: `imem_req` held 4 cycles, `imem_addr` stable, `instr_out` latches only the value present on the ready cycle, `instr_valid` pulses once.
- Halt: `halt`=1 in EXEC at PC 0x20: state HALTED, `pc_out`=0x24, `imem_req` stays 0 for 20 cycles, counters frozen; later `imem_ready` pulses are ignored.
- Reset and wrap:
  - `rst_n` pulsed low mid-FETCH: outputs go to reset values in the same cycle.
  - Preload `redirect_count` near 16'hFFFF via repeated taken branches: it saturates at FFFF.
  - PC 0xFFFF_FFFC sequential: next PC 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage.
// Fetches one instruction at a time over a ready-handshaked port, presents it
// for one EXEC cycle, then advances the PC (sequential, branch or jump) and
// updates the retire and redirect counters.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_src,
    input  logic        jump,
    input  logic [31:0] sign_imm,
    input  logic [25:0] jump_field,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_count,
    output logic [15:0] redirect_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    assign pc_out    = pc;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // Next-PC selection: jump has priority over a taken branch.
    always_comb begin
        jump_target   = {pc_plus4[31:28], jump_field, 2'b00};
        branch_target = pc_plus4 + (sign_imm << 2);
        next_pc       = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (pc_src) begin
            next_pc = branch_target;
        end
    end

    // Fetch/execute sequencer with registered handshake outputs, PC and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imem_req       <= 1'b0;
            instr_valid    <= 1'b0;
            instr_out      <= '0;
            retire_count   <= '0;
            redirect_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_out   <= instr_in;
                        state       <= EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    pc           <= next_pc;
                    retire_count <= retire_count + 32'd1;
                    if ((jump || pc_src) && (redirect_count != '1)) begin
                        redirect_count <= redirect_count + 16'd1;
                    end
                    instr_valid <= 1'b0;
                    if (halt) begin
                        state    <= HALTED;
                        imem_req <= 1'b0;
                    end else begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                HALTED: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized self-checking bench for pc_fetch_unit.
// A transaction-level model tracks the expected PC and counters per instruction.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pc_src = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] sign_imm = '0;
    logic [25:0] jump_field = '0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] instr_in = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] retire_count;
    logic [15:0] redirect_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [15:0] exp_red;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_src        (pc_src),
        .jump          (jump),
        .sign_imm      (sign_imm),
        .jump_field    (jump_field),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .instr_in      (instr_in),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .retire_count  (retire_count),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural next-PC rule.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic ps, input logic jp,
                                             input logic [31:0] imm, input logic [25:0] jf);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jp) return {p4[31:28], jf, 2'b00};
        if (ps) return p4 + (imm * 32'd4);
        return p4;
    endfunction

    // Drive don't-care control inputs with junk (they must be ignored outside EXEC).
    task automatic junk_ctrl();
        pc_src     = 1'($urandom);
        jump       = 1'($urandom);
        halt       = 1'($urandom);
        sign_imm   = $urandom;
        jump_field = 26'($urandom);
    endtask

    // Asynchronous reset applied at the current time; caller sits away from a posedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_req",   {31'd0, imem_req}, 32'd0);
        check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_val("rst_pc",    pc_out, RST_PC);
        check_val("rst_addr",  imem_addr, RST_PC);
        check_val("rst_pc4",   pc_plus4, RST_PC + 32'd4);
        check_val("rst_instr", instr_out, 32'd0);
        check_val("rst_ret",   retire_count, 32'd0);
        check_val("rst_red",   {16'd0, redirect_count}, 32'd0);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_pc  = RST_PC;
        exp_ret = '0;
        exp_red = '0;
        #1;
        check_val("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
    endtask

    // One instruction: entered at a negedge with the DUT in FETCH.
    task automatic do_instr(input int unsigned waits, input logic [31:0] instr, input logic ps,
                            input logic jp, input logic hl, input logic [31:0] imm,
                            input logic [25:0] jf);
        for (int unsigned c = 0; c <= waits; c++) begin
            check_val("f_req",   {31'd0, imem_req}, 32'd1);
            check_val("f_addr",  imem_addr, exp_pc);
            check_val("f_valid", {31'd0, instr_valid}, 32'd0);
            junk_ctrl();
            imem_ready = (c == waits);
            instr_in   = (c == waits) ? instr : $urandom;
            @(negedge clk);
        end
        check_val("x_valid", {31'd0, instr_valid}, 32'd1);
        check_val("x_req",   {31'd0, imem_req}, 32'd0);
        check_val("x_instr", instr_out, instr);
        check_val("x_pc",    pc_out, exp_pc);
        check_val("x_pc4",   pc_plus4, exp_pc + 32'd4);
        imem_ready = 1'($urandom);
        instr_in   = $urandom;
        pc_src     = ps;
        jump       = jp;
        halt       = hl;
        sign_imm   = imm;
        jump_field = jf;
        exp_pc  = ref_next(exp_pc, ps, jp, imm, jf);
        exp_ret = exp_ret + 32'd1;
        if ((ps || jp) && exp_red != 16'hFFFF) exp_red = exp_red + 16'd1;
        @(negedge clk);
        check_val("n_pc",  pc_out, exp_pc);
        check_val("n_ret", retire_count, exp_ret);
        check_val("n_red", {16'd0, redirect_count}, {16'd0, exp_red});
        imem_ready = 1'b0;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] diff;
        diff = target - exp_pc - 32'd4;
        do_instr(0, $urandom, 1'b1, 1'b0, 1'b0, diff >> 2, 26'($urandom));
    endtask

    initial begin
        logic [15:0] r0;
        #2;
        do_reset();

        // Sequential fetch from the reset PC with no wait states.
        do_instr(0, 32'h1111_1111, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom));
        check_val("seq1", pc_out, 32'h0040_0004);
        do_instr(0, 32'h2222_2222, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom));
        check_val("seq2", pc_out, 32'h0040_0008);
        do_instr(0, 32'h3333_3333, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom));
        check_val("seq3", pc_out, 32'h0040_000C);
        check_val("seq_ret", retire_count, 32'd3);

        // Backward and forward branches from 0x100.
        goto_pc(32'h0000_0100);
        r0 = exp_red;
        do_instr(0, $urandom, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'($urandom));
        check_val("br_back", pc_out, 32'h0000_00FC);
        check_val("br_red", {16'd0, redirect_count}, {16'd0, r0 + 16'd1});
        goto_pc(32'h0000_0100);
        do_instr(0, $urandom, 1'b1, 1'b0, 1'b0, 32'd3, 26'($urandom));
        check_val("br_fwd", pc_out, 32'h0000_0110);

        // Jump beats branch, single redirect increment.
        goto_pc(32'h9000_0010);
        r0 = exp_red;
        do_instr(0, $urandom, 1'b1, 1'b1, 1'b0, $urandom, 26'h000_0040);
        check_val("jmp_pc", pc_out, 32'h9000_0100);
        check_val("jmp_red", {16'd0, redirect_count}, {16'd0, r0 + 16'd1});

        // Wait states: three not-ready cycles before the ready one.
        do_instr(3, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom));

        // Sequential wrap of the PC.
        goto_pc(32'hFFFF_FFFC);
        do_instr(1, $urandom, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom));
        check_val("wrap", pc_out, 32'h0000_0000);

        // Random instruction stream.
        for (int unsigned i = 0; i < 60; i++) begin
            do_instr($urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), 1'b0, $urandom, 26'($urandom));
        end

        // Saturation: preset the counter close to the top, then take branches.
        force dut.redirect_count = 16'hFFFC;
        #1;
        release dut.redirect_count;
        exp_red = 16'hFFFC;
        for (int unsigned i = 0; i < 6; i++) begin
            do_instr(0, $urandom, 1'b1, 1'b0, 1'b0, $urandom, 26'($urandom));
        end
        check_val("sat", {16'd0, redirect_count}, 32'h0000_FFFF);

        // Halt at 0x20, then idle with ready pulses that must be ignored.
        goto_pc(32'h0000_0020);
        do_instr(0, $urandom, 1'b0, 1'b0, 1'b1, $urandom, 26'($urandom));
        check_val("halt_pc", pc_out, 32'h0000_0024);
        for (int unsigned i = 0; i < 20; i++) begin
            junk_ctrl();
            imem_ready = 1'($urandom);
            instr_in   = $urandom;
            @(negedge clk);
            check_val("h_req",   {31'd0, imem_req}, 32'd0);
            check_val("h_valid", {31'd0, instr_valid}, 32'd0);
            check_val("h_pc",    pc_out, 32'h0000_0024);
            check_val("h_ret",   retire_count, exp_ret);
            check_val("h_red",   {16'd0, redirect_count}, {16'd0, exp_red});
        end

        // Reset out of HALTED, then reset asserted mid-FETCH.
        do_reset();
        goto_pc(32'h0000_0400);
        imem_ready = 1'b0;
        check_val("mf_req", {31'd0, imem_req}, 32'd1);
        #2;
        do_reset();

        // Reset asserted mid-EXEC with a jump pending.
        do_instr(0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom));
        imem_ready = 1'b1;
        @(negedge clk);
        check_val("me_valid", {31'd0, instr_valid}, 32'd1);
        jump       = 1'b1;
        jump_field = 26'h3FF_FFFF;
        #2;
        do_reset();
        do_instr(0, $urandom, 1'b0, 1'b0, 1'b0, $urandom, 26'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
